// File: rtl/multi_class_centroid.sv
// Per-frame, per-class pixel statistics (count, coordinate sums, bounding box)
// turned into centroids by one shared serial divider and published double-buffered.

module mcc_class_acc #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int XW         = 10,
  parameter int YW         = 9,
  parameter int CW         = 19,
  parameter int SXW        = 29,
  parameter int SYW        = 28
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_flush,
  input  logic           i_hit,
  input  logic           i_eof,
  input  logic           i_snap,
  input  logic [XW-1:0]  i_x,
  input  logic [YW-1:0]  i_y,
  output logic [CW-1:0]  o_cnt,
  output logic [SXW-1:0] o_sx,
  output logic [SYW-1:0] o_sy,
  output logic [XW-1:0]  o_xmin,
  output logic [XW-1:0]  o_xmax,
  output logic [YW-1:0]  o_ymin,
  output logic [YW-1:0]  o_ymax
);

  typedef struct packed {
    logic [CW-1:0]  cnt;
    logic [SXW-1:0] sx;
    logic [SYW-1:0] sy;
    logic [XW-1:0]  xmin;
    logic [XW-1:0]  xmax;
    logic [YW-1:0]  ymin;
    logic [YW-1:0]  ymax;
  } acc_t;

  localparam acc_t ACC_INIT = {{CW{1'b0}}, {SXW{1'b0}}, {SYW{1'b0}},
                               XW'(IMG_WIDTH-1), {XW{1'b0}},
                               YW'(IMG_HEIGHT-1), {YW{1'b0}}};

  acc_t live_q, live_d, sh_q, sh_d, upd;

  always_comb begin
    upd = live_q;
    if (i_hit) begin
      upd.cnt = live_q.cnt + CW'(1);
      upd.sx  = live_q.sx + SXW'(i_x);
      upd.sy  = live_q.sy + SYW'(i_y);
      if (i_x < live_q.xmin) upd.xmin = i_x;
      if (i_x > live_q.xmax) upd.xmax = i_x;
      if (i_y < live_q.ymin) upd.ymin = i_y;
      if (i_y > live_q.ymax) upd.ymax = i_y;
    end
    live_d = upd;
    sh_d   = sh_q;
    if (i_flush) begin
      live_d = ACC_INIT;
      sh_d   = ACC_INIT;
    end else if (i_eof) begin
      // last pixel is folded in before the snapshot; live restarts on the same edge
      live_d = ACC_INIT;
      if (i_snap) sh_d = upd;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      live_q <= ACC_INIT;
      sh_q   <= ACC_INIT;
    end else begin
      live_q <= live_d;
      sh_q   <= sh_d;
    end
  end

  assign o_cnt  = sh_q.cnt;
  assign o_sx   = sh_q.sx;
  assign o_sy   = sh_q.sy;
  assign o_xmin = sh_q.xmin;
  assign o_xmax = sh_q.xmax;
  assign o_ymin = sh_q.ymin;
  assign o_ymax = sh_q.ymax;

endmodule

module multi_class_centroid #(
  parameter int IMG_WIDTH       = 640,
  parameter int IMG_HEIGHT      = 480,
  parameter int NUM_CLASSES     = 2,
  parameter int PIXEL_THRESHOLD = 1000,
  localparam int XW  = $clog2(IMG_WIDTH),
  localparam int YW  = $clog2(IMG_HEIGHT),
  localparam int CW  = $clog2(IMG_WIDTH*IMG_HEIGHT+1),
  localparam int SXW = XW + CW,
  localparam int SYW = YW + CW
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_flush,
  input  logic                      i_valid,
  input  logic [NUM_CLASSES-1:0]    i_class_flags,
  output logic [NUM_CLASSES*XW-1:0] o_centroid_x,
  output logic [NUM_CLASSES*YW-1:0] o_centroid_y,
  output logic [NUM_CLASSES*XW-1:0] o_bbox_xmin,
  output logic [NUM_CLASSES*XW-1:0] o_bbox_xmax,
  output logic [NUM_CLASSES*YW-1:0] o_bbox_ymin,
  output logic [NUM_CLASSES*YW-1:0] o_bbox_ymax,
  output logic [NUM_CLASSES-1:0]    o_obj_valid,
  output logic                      o_end_frame,
  output logic                      o_results_valid,
  output logic                      o_busy,
  output logic                      o_overrun
);

  localparam int DW = (SXW > SYW) ? SXW : SYW;
  localparam int BW = $clog2(DW+1);
  localparam int KW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [XW-1:0] XLAST = XW'(IMG_WIDTH-1);
  localparam logic [YW-1:0] YLAST = YW'(IMG_HEIGHT-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIVX = 2'd1;
  localparam logic [1:0] S_DIVY = 2'd2;
  localparam logic [1:0] S_PUB  = 2'd3;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          eof, snap;

  logic [NUM_CLASSES-1:0][CW-1:0]  cnt_sh;
  logic [NUM_CLASSES-1:0][SXW-1:0] sx_sh;
  logic [NUM_CLASSES-1:0][SYW-1:0] sy_sh;
  logic [NUM_CLASSES-1:0][XW-1:0]  xmin_sh, xmax_sh;
  logic [NUM_CLASSES-1:0][YW-1:0]  ymin_sh, ymax_sh;
  logic [NUM_CLASSES-1:0]          valid_sh;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] dvd_q, dvd_d, dvd_src, dvd_cur;
  logic [CW-1:0] rem_q, rem_d, rem_cur;
  logic [CW:0]   rem_sh;
  logic [DW-1:0] quo_q, quo_d, quo_cur, quo_nx;
  logic          first, ge;

  logic [NUM_CLASSES-1:0][XW-1:0] cx_st_q, cx_st_d, ocx_q, ocx_d;
  logic [NUM_CLASSES-1:0][YW-1:0] cy_st_q, cy_st_d, ocy_q, ocy_d;
  logic [NUM_CLASSES-1:0][XW-1:0] oxmin_q, oxmin_d, oxmax_q, oxmax_d;
  logic [NUM_CLASSES-1:0][YW-1:0] oymin_q, oymin_d, oymax_q, oymax_d;
  logic [NUM_CLASSES-1:0]         ovld_q, ovld_d;
  logic ef_q, ef_d, ov_q, ov_d, rv_q, rv_d, busy_q, busy_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    eof = i_valid && !i_flush && (x_q == XLAST) && (y_q == YLAST);
    if (i_flush) begin
      x_d = '0;
      y_d = '0;
    end else if (i_valid) begin
      if (x_q == XLAST) begin
        x_d = '0;
        y_d = (y_q == YLAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  assign snap = eof && (state_q == S_IDLE);

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cls
    mcc_class_acc #(
      .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT),
      .XW(XW), .YW(YW), .CW(CW), .SXW(SXW), .SYW(SYW)
    ) u_acc (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_flush(i_flush),
      .i_hit  (i_valid && i_class_flags[c]),
      .i_eof  (eof),
      .i_snap (snap),
      .i_x    (x_q),
      .i_y    (y_q),
      .o_cnt  (cnt_sh[c]),
      .o_sx   (sx_sh[c]),
      .o_sy   (sy_sh[c]),
      .o_xmin (xmin_sh[c]),
      .o_xmax (xmax_sh[c]),
      .o_ymin (ymin_sh[c]),
      .o_ymax (ymax_sh[c])
    );
    assign valid_sh[c] = 32'(cnt_sh[c]) >= PIXEL_THRESHOLD;
  end

  // Restoring divider step; the first cycle of each division takes its
  // dividend straight from the shadow, left-aligned so the MSB goes first.
  always_comb begin
    dvd_src = (state_q == S_DIVX) ? (DW'(sx_sh[k_q]) << (DW-SXW))
                                  : (DW'(sy_sh[k_q]) << (DW-SYW));
    first   = (bit_q == '0);
    dvd_cur = first ? dvd_src : dvd_q;
    rem_cur = first ? '0 : rem_q;
    quo_cur = first ? '0 : quo_q;
    rem_sh  = {rem_cur, dvd_cur[DW-1]};
    ge      = rem_sh >= {1'b0, cnt_sh[k_q]};
    quo_nx  = DW'({quo_cur, ge});
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    bit_d   = bit_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cx_st_d = cx_st_q;
    cy_st_d = cy_st_q;
    ocx_d   = ocx_q;
    ocy_d   = ocy_q;
    oxmin_d = oxmin_q;
    oxmax_d = oxmax_q;
    oymin_d = oymin_q;
    oymax_d = oymax_q;
    ovld_d  = ovld_q;
    rv_d    = 1'b0;
    ef_d    = eof;
    ov_d    = eof && (state_q != S_IDLE);
    if (i_flush) begin
      state_d = S_IDLE;
      k_d     = '0;
      bit_d   = '0;
      ef_d    = 1'b0;
      ov_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (eof) begin
            state_d = S_DIVX;
            k_d     = '0;
            bit_d   = '0;
          end
        end
        S_DIVX, S_DIVY: begin
          dvd_d = dvd_cur << 1;
          rem_d = CW'(ge ? rem_sh - {1'b0, cnt_sh[k_q]} : rem_sh);
          quo_d = quo_nx;
          bit_d = bit_q + BW'(1);
          // below-threshold classes still run the full division, result dropped
          if (state_q == S_DIVX && bit_q == BW'(SXW-1)) begin
            cx_st_d[k_q] = valid_sh[k_q] ? quo_nx[XW-1:0] : '0;
            state_d      = S_DIVY;
            bit_d        = '0;
          end else if (state_q == S_DIVY && bit_q == BW'(SYW-1)) begin
            cy_st_d[k_q] = valid_sh[k_q] ? quo_nx[YW-1:0] : '0;
            bit_d        = '0;
            if (k_q == KW'(NUM_CLASSES-1)) begin
              state_d = S_PUB;
            end else begin
              state_d = S_DIVX;
              k_d     = k_q + KW'(1);
            end
          end
        end
        default: begin
          ocx_d  = cx_st_q;
          ocy_d  = cy_st_q;
          ovld_d = valid_sh;
          for (int c = 0; c < NUM_CLASSES; c++) begin
            oxmin_d[c] = valid_sh[c] ? xmin_sh[c] : '0;
            oxmax_d[c] = valid_sh[c] ? xmax_sh[c] : '0;
            oymin_d[c] = valid_sh[c] ? ymin_sh[c] : '0;
            oymax_d[c] = valid_sh[c] ? ymax_sh[c] : '0;
          end
          rv_d    = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
    // busy covers the cycle in which results_valid is shown
    busy_d = !i_flush && ((state_d != S_IDLE) || (state_q == S_PUB));
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      x_q     <= '0;
      y_q     <= '0;
      state_q <= S_IDLE;
      k_q     <= '0;
      bit_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cx_st_q <= '0;
      cy_st_q <= '0;
      ocx_q   <= '0;
      ocy_q   <= '0;
      oxmin_q <= '0;
      oxmax_q <= '0;
      oymin_q <= '0;
      oymax_q <= '0;
      ovld_q  <= '0;
      ef_q    <= 1'b0;
      ov_q    <= 1'b0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      state_q <= state_d;
      k_q     <= k_d;
      bit_q   <= bit_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cx_st_q <= cx_st_d;
      cy_st_q <= cy_st_d;
      ocx_q   <= ocx_d;
      ocy_q   <= ocy_d;
      oxmin_q <= oxmin_d;
      oxmax_q <= oxmax_d;
      oymin_q <= oymin_d;
      oymax_q <= oymax_d;
      ovld_q  <= ovld_d;
      ef_q    <= ef_d;
      ov_q    <= ov_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
    end
  end

  assign o_centroid_x    = ocx_q;
  assign o_centroid_y    = ocy_q;
  assign o_bbox_xmin     = oxmin_q;
  assign o_bbox_xmax     = oxmax_q;
  assign o_bbox_ymin     = oymin_q;
  assign o_bbox_ymax     = oymax_q;
  assign o_obj_valid     = ovld_q;
  assign o_busy          = busy_q;
  assign o_end_frame     = ef_q & ~i_flush;
  assign o_overrun       = ov_q & ~i_flush;
  assign o_results_valid = rv_q & ~i_flush;

endmodule

// File: tb/tb_multi_class_centroid.sv
// Scoreboard bench for multi_class_centroid on an 8x4 image with two classes.

module tb_multi_class_centroid;
  localparam int LAT = 35;

  logic       clk = 1'b0, rstn = 1'b0, flush = 1'b0, valid = 1'b0;
  logic [1:0] flags = '0;
  logic [5:0] cx, xmn, xmx;
  logic [3:0] cy, ymn, ymx;
  logic [1:0] ov;
  logic       ef, rv, busy, ovr;

  always #5 clk = ~clk;

  multi_class_centroid #(
    .IMG_WIDTH(8), .IMG_HEIGHT(4), .NUM_CLASSES(2), .PIXEL_THRESHOLD(2)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(valid),
    .i_class_flags(flags),
    .o_centroid_x(cx), .o_centroid_y(cy),
    .o_bbox_xmin(xmn), .o_bbox_xmax(xmx),
    .o_bbox_ymin(ymn), .o_bbox_ymax(ymx),
    .o_obj_valid(ov), .o_end_frame(ef), .o_results_valid(rv),
    .o_busy(busy), .o_overrun(ovr)
  );

  typedef struct packed {
    logic       v;
    logic [2:0] cx;
    logic [1:0] cy;
    logic [2:0] xmn, xmx;
    logic [1:0] ymn, ymx;
  } cls_t;
  typedef struct packed { cls_t c1; cls_t c0; } exp_t;

  exp_t exp_q[$];
  logic ovr_q[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, ef_cyc = -1000;
  logic [1:0] frm [32];
  exp_t E1, EZ, E3, FL;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic cls_t mk(input logic v, input int x_c, input int y_c,
                              input int x0, input int x1, input int y0, input int y1);
    cls_t r;
    r.v = v; r.cx = 3'(x_c); r.cy = 2'(y_c);
    r.xmn = 3'(x0); r.xmx = 3'(x1); r.ymn = 2'(y0); r.ymx = 2'(y1);
    return r;
  endfunction

  function automatic cls_t act_cls(input int c);
    cls_t r;
    r.v = ov[c]; r.cx = cx[c*3 +: 3]; r.cy = cy[c*2 +: 2];
    r.xmn = xmn[c*3 +: 3]; r.xmx = xmx[c*3 +: 3];
    r.ymn = ymn[c*2 +: 2]; r.ymx = ymx[c*2 +: 2];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: pops expectations whenever the DUT signals an event.
  always @(negedge clk) begin
    exp_t e;
    logic eo;
    if (rstn) begin
      if (ef) begin
        if (ovr_q.size() == 0) chk("end_frame with nothing queued", ef, 1'b0);
        else begin
          eo = ovr_q.pop_front();
          chk("overrun", ovr, eo);
        end
        chk("busy at end_frame", busy, 1'b1);
        if (!ovr) ef_cyc = cyc;
      end
      if (rv) begin
        chk("latency", 64'(cyc - ef_cyc), LAT);
        if (exp_q.size() == 0) chk("results_valid with nothing queued", rv, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("class0", act_cls(0), e.c0);
          chk("class1", act_cls(1), e.c1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_frm();
    for (int p = 0; p < 32; p++) frm[p] = 2'b00;
  endtask

  task automatic send_frame(input int gap);
    for (int p = 0; p < 32; p++) begin
      valid = 1'b1; flags = frm[p];
      tick();
      valid = 1'b0; flags = 2'b00;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (3) tick();
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("busy drop", busy, 1'b0);
  endtask

  task automatic load_e1();
    clr_frm();
    frm[10] = 2'b01; frm[12] = 2'b01; frm[26] = 2'b01; frm[28] = 2'b01;
    frm[5]  = 2'b10;
  endtask

  task automatic load_e3();
    clr_frm();
    frm[0] = 2'b01; frm[31] = 2'b01; frm[1] = 2'b10; frm[22] = 2'b10;
  endtask

  task automatic load_flood();
    for (int p = 0; p < 32; p++) frm[p] = 2'b10;
  endtask

  initial begin
    E1 = {mk(0,0,0,0,0,0,0), mk(1,3,2,2,4,1,3)};
    EZ = '0;
    E3 = {mk(1,3,1,1,6,0,2), mk(1,3,1,0,7,0,3)};
    FL = {mk(1,3,1,0,7,0,3), mk(0,0,0,0,0,0,0)};

    tick(); tick();
    chk("reset outputs", {cx, cy, xmn, xmx, ymn, ymx, ov, ef, rv, busy, ovr}, 64'd0);
    rstn = 1'b1;
    tick();

    // basic centroid, class1 under threshold
    load_e1(); exp_q.push_back(E1); ovr_q.push_back(1'b0);
    send_frame(2); wait_idle();

    // empty frame
    clr_frm(); exp_q.push_back(EZ); ovr_q.push_back(1'b0);
    send_frame(2); wait_idle();

    // first/last pixel and count exactly at threshold
    load_e3(); exp_q.push_back(E3); ovr_q.push_back(1'b0);
    send_frame(2); wait_idle();

    // flood fill
    load_flood(); exp_q.push_back(FL); ovr_q.push_back(1'b0);
    send_frame(2); wait_idle();

    // back-to-back: second frame end lands while busy
    load_e1(); exp_q.push_back(E1); ovr_q.push_back(1'b0);
    send_frame(0);
    load_flood(); ovr_q.push_back(1'b1);
    send_frame(0); wait_idle();
    chk("b2b hold c0", act_cls(0), E1.c0);
    chk("b2b hold c1", act_cls(1), E1.c1);

    // flush during division: no publish, outputs held
    load_e3(); ovr_q.push_back(1'b0);
    send_frame(2);
    repeat (10) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (40) tick();
    chk("abort hold c0", act_cls(0), E1.c0);
    chk("abort hold c1", act_cls(1), E1.c1);
    chk("abort busy", busy, 1'b0);

    // flush mid-frame, then a clean frame
    for (int p = 0; p < 10; p++) begin
      valid = 1'b1; flags = 2'b01; tick();
      valid = 1'b0; flags = 2'b00; tick(); tick();
    end
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush hold c0", act_cls(0), E1.c0);
    load_flood(); exp_q.push_back(FL); ovr_q.push_back(1'b0);
    send_frame(2); wait_idle();

    // async reset during division
    load_e3(); exp_q.push_back(E3); ovr_q.push_back(1'b0);
    send_frame(2);
    repeat (12) tick();
    rstn = 1'b0;
    #1;
    chk("reset mid-div", {cx, cy, xmn, xmx, ymn, ymx, ov, ef, rv, busy, ovr}, 64'd0);
    void'(exp_q.pop_back());
    tick();
    rstn = 1'b1;
    tick();
    load_e1(); exp_q.push_back(E1); ovr_q.push_back(1'b0);
    send_frame(2); wait_idle();

    repeat (5) tick();
    chk("queues drained", 64'(exp_q.size() + ovr_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
